// File: rtl/gemm_result_writer_pkg.sv
// Shared widths, state encoding and helpers for the GEMM result writer.
// The packer works on whole bytes, so element width and lanes per word are fixed here.
package gemm_result_writer_pkg;

    localparam int DATA_WIDTH      = 8;
    localparam int MAX_VECTOR_SIZE = 8;
    localparam int SRAM_WIDTH_O    = DATA_WIDTH * MAX_VECTOR_SIZE;
    localparam int MAX_ADDR_WIDTH  = 18;
    localparam int DEF_CNT_WIDTH   = 20;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int LANE_CNT_WIDTH  = $clog2(MAX_VECTOR_SIZE) + 1;
    localparam int FILL_WIDTH      = $clog2(MAX_VECTOR_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Byte enables for a partial word holding 'fill' elements in the low lanes.
    function automatic logic [MAX_VECTOR_SIZE-1:0] low_strobe(input logic [FILL_WIDTH-1:0] fill);
        logic [MAX_VECTOR_SIZE-1:0] s;
        s = '0;
        for (int i = 0; i < MAX_VECTOR_SIZE; i++) begin
            if (i < int'(fill)) s[i] = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/gemm_result_writer_fifo.sv
// Small synchronous FIFO with first-word-fall-through head; push on a full FIFO
// succeeds when a pop happens in the same cycle.
module gemm_result_writer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr_reg;
    logic [PTR_W:0]   rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
    end

    assign head_data = mem[rd_ptr_reg[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/gemm_result_writer.sv
// Packs requantized int8 result beats into 64-bit SRAM words, buffers them and
// writes them out from a programmable base address, pulsing done at job end.
module gemm_result_writer
    import gemm_result_writer_pkg::*;
#(
    parameter int ADDR_WIDTH = MAX_ADDR_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        init,
    input  logic                        start,
    input  logic [ADDR_WIDTH-1:0]       base_addr,
    input  logic [CNT_WIDTH-1:0]        total_elems,
    input  logic                        in_valid,
    input  logic [SRAM_WIDTH_O-1:0]     in_data,
    input  logic [LANE_CNT_WIDTH-1:0]   in_lanes,
    output logic                        sram_we,
    input  logic                        sram_ready,
    output logic [ADDR_WIDTH-1:0]       sram_addr,
    output logic [SRAM_WIDTH_O-1:0]     sram_wdata,
    output logic [MAX_VECTOR_SIZE-1:0]  sram_wstrb,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow
);

    localparam int ENTRY_W    = SRAM_WIDTH_O + MAX_VECTOR_SIZE + ADDR_WIDTH;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int REL_W      = LANE_CNT_WIDTH + 1;

    state_t                    state_reg, state_next;
    logic [CNT_WIDTH-1:0]      total_reg;
    logic [CNT_WIDTH-1:0]      elem_cnt_reg;
    logic [SRAM_WIDTH_O-1:0]   word_reg;
    logic [FILL_WIDTH-1:0]     fill_reg;
    logic [ADDR_WIDTH-1:0]     push_addr_reg;
    logic                      overflow_reg;

    logic [CNT_WIDTH-1:0]      remaining;
    logic [LANE_CNT_WIDTH-1:0] lanes_capped;
    logic [LANE_CNT_WIDTH-1:0] beat_n;
    logic [LANE_CNT_WIDTH-1:0] fill_sum;
    logic                      beat_fire;
    logic                      beat_full;
    logic                      beat_last;
    logic [2*SRAM_WIDTH_O-1:0] ext_word;

    logic                      fifo_push;
    logic [ENTRY_W-1:0]        fifo_push_data;
    logic                      fifo_pop;
    logic [ENTRY_W-1:0]        fifo_head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [FIFO_CNT_W-1:0]     fifo_count;
    logic                      fifo_space;
    logic                      overflow_set;

    logic [SRAM_WIDTH_O-1:0]   head_wdata;
    logic [MAX_VECTOR_SIZE-1:0] head_wstrb;
    logic [ADDR_WIDTH-1:0]     head_addr;

    assign remaining    = total_reg - elem_cnt_reg;
    assign lanes_capped = (in_lanes > LANE_CNT_WIDTH'(MAX_VECTOR_SIZE)) ?
                          LANE_CNT_WIDTH'(MAX_VECTOR_SIZE) : in_lanes;
    assign beat_n       = (remaining < CNT_WIDTH'(lanes_capped)) ?
                          remaining[LANE_CNT_WIDTH-1:0] : lanes_capped;
    assign fill_sum     = LANE_CNT_WIDTH'(fill_reg) + beat_n;
    assign beat_fire    = (state_reg == ST_RUN) && in_valid && (beat_n != '0);
    assign beat_full    = (fill_sum >= LANE_CNT_WIDTH'(MAX_VECTOR_SIZE));
    assign beat_last    = (remaining == CNT_WIDTH'(beat_n));

    // Two-word window: partial word in bytes 0..fill-1, new lanes right after it.
    // The upper half carries the leftover that starts the next partial word.
    genvar gi;
    generate
        for (gi = 0; gi < 2*MAX_VECTOR_SIZE; gi++) begin : g_ext
            logic [REL_W-1:0] rel;
            logic             in_window;
            assign rel       = REL_W'(gi) - REL_W'(fill_reg);
            assign in_window = (rel < REL_W'(beat_n));
            if (gi < MAX_VECTOR_SIZE) begin : g_lo
                assign ext_word[DATA_WIDTH*gi +: DATA_WIDTH] =
                    (int'(fill_reg) > gi) ? word_reg[DATA_WIDTH*gi +: DATA_WIDTH] :
                    in_window ? in_data[DATA_WIDTH*rel[FILL_WIDTH-1:0] +: DATA_WIDTH] : '0;
            end else begin : g_hi
                assign ext_word[DATA_WIDTH*gi +: DATA_WIDTH] =
                    in_window ? in_data[DATA_WIDTH*rel[FILL_WIDTH-1:0] +: DATA_WIDTH] : '0;
            end
        end
    endgenerate

    assign fifo_pop   = !fifo_empty && sram_ready;
    assign fifo_space = !fifo_full || fifo_pop;

    always_comb begin
        state_next     = state_reg;
        fifo_push      = 1'b0;
        fifo_push_data = {ext_word[SRAM_WIDTH_O-1:0], {MAX_VECTOR_SIZE{1'b1}}, push_addr_reg};
        overflow_set   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = (total_elems == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (beat_fire) begin
                    if (beat_full) begin
                        fifo_push    = fifo_space;
                        overflow_set = !fifo_space;
                    end
                    if (beat_last) state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Partial word waits for space here instead of being dropped.
                if (fill_reg != '0) begin
                    fifo_push_data = {word_reg, low_strobe(fill_reg), push_addr_reg};
                    fifo_push      = fifo_space;
                end else if (fifo_empty || (fifo_count == FIFO_CNT_W'(1) && fifo_pop)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            total_reg     <= '0;
            elem_cnt_reg  <= '0;
            word_reg      <= '0;
            fill_reg      <= '0;
            push_addr_reg <= '0;
            overflow_reg  <= 1'b0;
        end else if (init) begin
            state_reg     <= ST_IDLE;
            total_reg     <= '0;
            elem_cnt_reg  <= '0;
            word_reg      <= '0;
            fill_reg      <= '0;
            push_addr_reg <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            overflow_reg <= overflow_reg | overflow_set;
            if (fifo_push) push_addr_reg <= push_addr_reg + 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        total_reg     <= total_elems;
                        elem_cnt_reg  <= '0;
                        word_reg      <= '0;
                        fill_reg      <= '0;
                        push_addr_reg <= base_addr;
                    end
                end
                ST_RUN: begin
                    if (beat_fire) begin
                        elem_cnt_reg <= elem_cnt_reg + CNT_WIDTH'(beat_n);
                        word_reg     <= beat_full ? ext_word[2*SRAM_WIDTH_O-1:SRAM_WIDTH_O]
                                                  : ext_word[SRAM_WIDTH_O-1:0];
                        fill_reg     <= fill_sum[FILL_WIDTH-1:0];
                    end
                end
                ST_FLUSH: begin
                    if (fifo_push) begin
                        word_reg <= '0;
                        fill_reg <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    gemm_result_writer_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (init),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign {head_wdata, head_wstrb, head_addr} = fifo_head;

    assign sram_we    = !fifo_empty;
    assign sram_addr  = fifo_empty ? '0 : head_addr;
    assign sram_wdata = fifo_empty ? '0 : head_wdata;
    assign sram_wstrb = fifo_empty ? '0 : head_wstrb;
    assign busy       = (state_reg != ST_IDLE);
    assign done       = (state_reg == ST_DONE);
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_gemm_result_writer.sv
// Directed and randomized checks of gemm_result_writer against an element-list model.
module tb_gemm_result_writer;

    localparam int AW = 18;
    localparam int CW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          init = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] total_elems = '0;
    logic          in_valid = 1'b0;
    logic [63:0]   in_data = '0;
    logic [3:0]    in_lanes = '0;
    logic          sram_ready = 1'b0;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [63:0]   sram_wdata;
    logic [7:0]    sram_wstrb;
    logic          busy;
    logic          done;
    logic          overflow;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    logic [AW-1:0] wr_addr_q[$];
    logic [63:0]   wr_data_q[$];
    logic [7:0]    wr_strb_q[$];
    int            last_wr_cyc = -1;
    int            done_cnt = 0;
    int            done_cyc = -1;

    logic [7:0]    elem_q[$];
    int            job_total = 0;
    logic [AW-1:0] job_base = '0;
    int            start_cyc = 0;

    gemm_result_writer dut (
        .clk         (clk),
        .rst         (rst),
        .init        (init),
        .start       (start),
        .base_addr   (base_addr),
        .total_elems (total_elems),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_lanes    (in_lanes),
        .sram_we     (sram_we),
        .sram_ready  (sram_ready),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_wstrb  (sram_wstrb),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Inputs change 1 time unit after the rising edge, so the falling edge sees
    // exactly the values the next rising edge will act on.
    always @(negedge clk) begin
        if (rst && sram_we && sram_ready) begin
            wr_addr_q.push_back(sram_addr);
            wr_data_q.push_back(sram_wdata);
            wr_strb_q.push_back(sram_wstrb);
            last_wr_cyc = cyc;
        end
        if (rst && done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] exp_data(input int k);
        logic [63:0] d = '0;
        for (int j = 0; j < 8; j++) begin
            if (8*k + j < job_total) d[8*j +: 8] = elem_q[8*k + j];
        end
        return d;
    endfunction

    function automatic logic [7:0] exp_strb(input int k);
        logic [7:0] s = '0;
        for (int j = 0; j < 8; j++) begin
            if (8*k + j < job_total) s[j] = 1'b1;
        end
        return s;
    endfunction

    task automatic start_job(input logic [AW-1:0] base, input int total);
        job_base  = base;
        job_total = total;
        elem_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_strb_q.delete();
        done_cnt    = 0;
        done_cyc    = -1;
        last_wr_cyc = -1;
        base_addr   = base;
        total_elems = CW'(total);
        start       = 1'b1;
        in_valid    = 1'b1;
        in_lanes    = 4'd8;
        in_data     = {$urandom, $urandom};
        start_cyc   = cyc;
        tick();
        start       = 1'b0;
        in_valid    = 1'b0;
        base_addr   = AW'($urandom);
        total_elems = CW'($urandom);
        chk("busy_after_start", 64'(busy), 64'(1));
    endtask

    task automatic beat(input int lanes);
        logic [63:0] d;
        int n;
        int rem;
        d        = {$urandom, $urandom};
        in_valid = 1'b1;
        in_lanes = 4'(lanes);
        in_data  = d;
        rem = job_total - elem_q.size();
        n   = (lanes > 8) ? 8 : lanes;
        if (n > rem) n = rem;
        for (int j = 0; j < n; j++) elem_q.push_back(d[8*j +: 8]);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle(input logic with_valid);
        in_valid = with_valid;
        in_lanes = 4'($urandom_range(1, 8));
        in_data  = {$urandom, $urandom};
        tick();
        in_valid = 1'b0;
    endtask

    task automatic finish_job(input int skip_word, input logic exp_ovf, input logic rand_ready);
        int guard;
        int n_words;
        int n_exp;
        int w;
        logic [AW-1:0] ea;
        guard = 0;
        while (done_cnt == 0 && guard < 3000) begin
            sram_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            guard++;
        end
        chk("done_seen", 64'(done_cnt > 0), 64'(1));
        sram_ready = 1'b1;
        tick();
        tick();
        chk("done_pulses", 64'(done_cnt), 64'(1));
        chk("busy_idle", 64'(busy), 64'(0));
        chk("overflow_flag", 64'(overflow), 64'(exp_ovf));
        chk("we_idle", 64'(sram_we), 64'(0));
        n_words = (job_total + 7) / 8;
        n_exp   = n_words - ((skip_word >= 0) ? 1 : 0);
        chk("write_count", 64'(wr_addr_q.size()), 64'(n_exp));
        w = 0;
        for (int k = 0; k < n_words; k++) begin
            if (k != skip_word) begin
                if (w < wr_addr_q.size()) begin
                    ea = job_base + AW'(k);
                    chk("wr_addr", 64'(wr_addr_q[w]), 64'(ea));
                    chk("wr_data", wr_data_q[w], exp_data(k));
                    chk("wr_strb", 64'(wr_strb_q[w]), 64'(exp_strb(k)));
                end
                w++;
            end
        end
        if (job_total == 0) chk("done_latency", 64'(done_cyc), 64'(start_cyc + 1));
        else                chk("done_latency", 64'(done_cyc), 64'(last_wr_cyc + 1));
        $display("job base=%0h total=%0d writes=%0d done_cyc=%0d", job_base, job_total,
                 wr_addr_q.size(), done_cyc);
    endtask

    task automatic rand_job();
        int guard;
        int outstanding;
        logic [AW-1:0] base;
        base = AW'($urandom);
        idle_cycle(1'b1);
        start_job(base, $urandom_range(0, 60));
        guard = 0;
        while (elem_q.size() < job_total && guard < 2000) begin
            sram_ready  = ($urandom_range(0, 3) != 0);
            outstanding = elem_q.size() / 8 - wr_addr_q.size();
            if (outstanding <= 2 && $urandom_range(0, 2) != 0) beat($urandom_range(0, 15));
            else idle_cycle(1'b0);
            guard++;
        end
        finish_job(-1, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset values
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 64'(sram_we), 64'(0));
        chk("rst_addr", 64'(sram_addr), 64'(0));
        chk("rst_wdata", sram_wdata, 64'(0));
        chk("rst_wstrb", 64'(sram_wstrb), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        rst = 1'b1;
        tick();

        // Two full beats, write issued the cycle after the first word completes
        sram_ready = 1'b1;
        start_job(18'h00100, 16);
        beat(8);
        chk("first_we", 64'(sram_we), 64'(1));
        chk("first_addr", 64'(sram_addr), 64'(18'h00100));
        chk("first_strb", 64'(sram_wstrb), 64'(8'hFF));
        beat(8);
        finish_job(-1, 1'b0, 1'b0);

        // 5+5+5 lanes against 13 elements: last two lanes discarded, partial flush
        start_job(18'h00100, 13);
        beat(5);
        beat(5);
        beat(5);
        finish_job(-1, 1'b0, 1'b0);

        // Stalled SRAM: four queued words stay stable, the fifth is dropped
        sram_ready = 1'b0;
        start_job(18'h00200, 40);
        for (int i = 0; i < 4; i++) beat(8);
        for (int i = 0; i < 10; i++) begin
            chk("stall_we", 64'(sram_we), 64'(1));
            chk("stall_addr", 64'(sram_addr), 64'(18'h00200));
            chk("stall_data", sram_wdata, exp_data(0));
            chk("stall_strb", 64'(sram_wstrb), 64'(8'hFF));
            tick();
        end
        chk("stall_no_ovf", 64'(overflow), 64'(0));
        beat(8);
        chk("stall_ovf", 64'(overflow), 64'(1));
        finish_job(4, 1'b1, 1'b0);

        init = 1'b1;
        tick();
        init = 1'b0;
        chk("init_ovf_clear", 64'(overflow), 64'(0));
        chk("init_busy", 64'(busy), 64'(0));

        // Address wrap at the top of the SRAM
        start_job(18'h3FFFF, 16);
        beat(8);
        beat(8);
        finish_job(-1, 1'b0, 1'b0);

        // Empty job
        start_job(18'h00050, 0);
        finish_job(-1, 1'b0, 1'b0);

        // init mid-job: queued words discarded, no done
        sram_ready = 1'b0;
        start_job(18'h00300, 24);
        beat(8);
        beat(8);
        chk("pre_init_we", 64'(sram_we), 64'(1));
        init = 1'b1;
        tick();
        init = 1'b0;
        chk("post_init_we", 64'(sram_we), 64'(0));
        chk("post_init_busy", 64'(busy), 64'(0));
        sram_ready = 1'b1;
        repeat (5) tick();
        chk("init_no_done", 64'(done_cnt), 64'(0));
        chk("init_no_writes", 64'(wr_addr_q.size()), 64'(0));

        // Asynchronous reset mid-job
        sram_ready = 1'b0;
        start_job(18'h00400, 32);
        beat(8);
        beat(8);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_we", 64'(sram_we), 64'(0));
        chk("arst_addr", 64'(sram_addr), 64'(0));
        chk("arst_wdata", sram_wdata, 64'(0));
        chk("arst_wstrb", 64'(sram_wstrb), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_done", 64'(done), 64'(0));
        chk("arst_overflow", 64'(overflow), 64'(0));
        sram_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("arst_no_done", 64'(done_cnt), 64'(0));
        chk("arst_no_writes", 64'(wr_addr_q.size()), 64'(0));
        start_job(18'h00500, 16);
        beat(8);
        beat(8);
        finish_job(-1, 1'b0, 1'b0);

        // Randomized jobs with random lane counts and SRAM backpressure
        for (int r = 0; r < 25; r++) rand_job();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/gemm_result_writer.md
# gemm_result_writer

Receiving end of the GEMM requantized-output stream. Accepts per-cycle vectors of up to 8 signed int8 results, with a valid-lane count, and packs them contiguously into 64-bit output-SRAM words. It buffers packed words in a small FIFO and writes them to SRAM through a ready/valid write port, starting at a programmable base address. It signals completion after a programmed element count has been written, including a final partial word.

## Interface
- DATA_WIDTH, 8, bits per result element
- MAX_VECTOR_SIZE, 8, lanes per input beat; SRAM word holds MAX_VECTOR_SIZE elements
- ADDR_WIDTH, 18, SRAM word-address width
- CNT_WIDTH, 20, element-count width
- FIFO_DEPTH, 4, packed-word buffer entries (power of two)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- init  in  1  synchronous clear to IDLE; clears counters, FIFO and overflow
- start  in  1  one-cycle job launch; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first SRAM word address, captured at start
- total_elems  in  CNT_WIDTH  elements in the job, captured at start
- in_valid  in  1  input beat valid (GEMM conv/fc valid)
- in_data  in  MAX_VECTOR_SIZE*DATA_WIDTH  lane i at bits [8i+7:8i]
- in_lanes  in  4  valid lanes in the beat, lanes 0..in_lanes-1
- sram_we  out  1  write request
- sram_ready  in  1  SRAM accepts the write this cycle
- sram_addr  out  ADDR_WIDTH  write word address
- sram_wdata  out  MAX_VECTOR_SIZE*DATA_WIDTH  packed word
- sram_wstrb  out  MAX_VECTOR_SIZE  byte enables
- busy  out  1  high outside IDLE
- done  out  1  one-cycle completion pulse
- overflow  out  1  sticky: a packed word was dropped because the FIFO was full

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: on start, capture base_addr and total_elems, clear counters, go to RUN. If total_elems==0, go directly to DONE.
- RUN, per in_valid beat: n = min(in_lanes, 8, remaining elements). in_lanes==0 is a no-op. Lanes beyond remaining are discarded.
- Packer holds a partial word and fill (0..7). Lanes are appended at byte positions fill..fill+n-1.
- If fill+n ≥ 8, push the full word with wstrb=8'hFF. The leftover lanes start the next partial word with fill=fill+n-8. At most one push per beat.
- After the beat that reaches total_elems: if fill>0, go to FLUSH; otherwise go to FLUSH with nothing to push.
- FLUSH: push the partial word, with unused bytes zero and wstrb having the low fill bits set, once the FIFO has space. Then wait for the FIFO to drain, then go to DONE.
- Push with FIFO full in RUN: the word is dropped, overflow is set, and counters advance anyway. In FLUSH, the push waits instead.
- Writer: sram_we = FIFO not empty, with data, strobe and address from the FIFO head. On sram_we && sram_ready, pop and increment the address. The address wraps modulo 2^ADDR_WIDTH.
- DONE: done=1 for one cycle, then IDLE.
- in_valid outside RUN and start outside IDLE are ignored.
- init has priority over all other inputs. rst and init mid-job abort the job with no done and no further writes.

## Timing
- Reset values: sram_we=0, sram_addr=0, sram_wdata=0, sram_wstrb=0, busy=0, done=0, overflow=0. State is IDLE, FIFO empty, fill=0.
- If a beat completes a word at edge t, sram_we is high in cycle t+1 if the FIFO was empty.
- Write outputs are held stable while sram_we && !sram_ready.
- Simultaneous push and pop on a full FIFO: the push succeeds and no overflow is flagged.
- Maximum sustained rate is one word per cycle with sram_ready held high.
- done asserts the cycle after the final pop handshake.
- start is captured one cycle before RUN accepts beats, so a beat coincident with start is ignored.

## Structure
- Shared params.vh holds DATA_WIDTH, MAX_VECTOR_SIZE, SRAM_WIDTH_O, MAX_ADDR_WIDTH and the state encodings.
- Sub-module result_fifo: synchronous FIFO with FIFO_DEPTH entries of {wdata, wstrb, addr}, providing full, empty and count.
- Packer, FSM and address counter live in the top module.

## Test plan
- base=0x100, total=16, two 8-lane beats, ready=1 → writes at 0x100 and 0x101, wstrb=FF each, done 1 cycle after second pop.
- total=13, beats of 5, 5, 5 lanes → word 0x100 holds elements 0–7 (FF), word 0x101 holds 8–12 (wstrb=1F, bytes 5–7 zero); last 2 lanes are dropped.
- sram_ready low for 10 cycles with 4 full words queued → outputs stable, no overflow; 5th word → overflow=1, only 4 writes occur.
- base=0x3FFFF, total=16 → writes at 0x3FFFF then 0x00000.
- total=0 → done on the cycle after start, no sram_we.
- Assert rst low mid-RUN with words queued → all outputs reset immediately, no done, next job behaves normally.
